// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state encodings and ALU selects for the teaching-CPU control unit
package cpu_ctrl_pkg;

    localparam logic [3:0] OPC_LOAD = 4'b0000;
    localparam logic [3:0] OPC_MOVE = 4'b0001;
    localparam logic [3:0] OPC_ADD  = 4'b0010;
    localparam logic [3:0] OPC_XOR  = 4'b0011;
    localparam logic [3:0] OPC_SUB  = 4'b0100;
    localparam logic [3:0] OPC_AND  = 4'b0101;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_MOVE = 3'd2;
    localparam state_t ST_EX1  = 3'd3;
    localparam state_t ST_EX2  = 3'd4;
    localparam state_t ST_EX3  = 3'd5;
    localparam state_t ST_ERR  = 3'd6;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 2'b00;
    localparam alu_op_t ALU_XOR = 2'b01;
    localparam alu_op_t ALU_SUB = 2'b10;
    localparam alu_op_t ALU_AND = 2'b11;

    function automatic alu_op_t alu_sel(input logic [3:0] opc);
        case (opc)
            OPC_XOR: alu_sel = ALU_XOR;
            OPC_SUB: alu_sel = ALU_SUB;
            OPC_AND: alu_sel = ALU_AND;
            default: alu_sel = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction handshake and datapath strobe bundle of the control unit
interface cpu_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3
);
    localparam int NREG = 2 ** ARG_SIZE;
    localparam int IW   = OP_SIZE + 2 * ARG_SIZE;

    logic            instr_valid;
    logic            instr_ready;
    logic [IW-1:0]   instruction;
    logic [NREG-1:0] reg_en;
    logic [NREG-1:0] reg_tri;
    logic            data_tri;
    logic            a_en;
    logic            g_en;
    logic            g_tri;
    alu_op_t         alu_op;
    logic            done;
    logic            illegal;
    logic            busy;

    modport master (
        output instr_valid, instruction,
        input  instr_ready, reg_en, reg_tri, data_tri, a_en, g_en, g_tri,
               alu_op, done, illegal, busy
    );

    modport slave (
        input  instr_valid, instruction,
        output instr_ready, reg_en, reg_tri, data_tri, a_en, g_en, g_tri,
               alu_op, done, illegal, busy
    );

endinterface

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - register index plus enable to one-hot vector
module onehot_decoder #(
    parameter int ARG_SIZE = 3
) (
    input  logic [ARG_SIZE-1:0]      idx,
    input  logic                     en,
    output logic [2**ARG_SIZE-1:0]   onehot
);
    localparam int NREG = 2 ** ARG_SIZE;

    assign onehot = en ? (NREG'(1) << idx) : '0;

endmodule

// File: rtl/cpu_ctrl_unit.sv
// rtl/cpu_ctrl_unit.sv - multi-cycle Moore controller sequencing register, bus and ALU strobes
module cpu_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3
) (
    input  logic     clk,
    input  logic     rst,
    cpu_ctrl_if.slave bus
);
    localparam int IW = OP_SIZE + 2 * ARG_SIZE;

    state_t              state;
    state_t              next_state;
    logic [OP_SIZE-1:0]  op_q;
    logic [ARG_SIZE-1:0] x_q;
    logic [ARG_SIZE-1:0] y_q;

    logic [OP_SIZE-1:0]  op_in;
    logic [ARG_SIZE-1:0] x_in;
    logic [ARG_SIZE-1:0] y_in;
    logic                accept;

    logic                en_on;
    logic                tr_on;
    logic [ARG_SIZE-1:0] tr_idx;

    assign op_in  = bus.instruction[IW-1 -: OP_SIZE];
    assign x_in   = bus.instruction[2*ARG_SIZE-1 -: ARG_SIZE];
    assign y_in   = bus.instruction[ARG_SIZE-1:0];
    assign accept = bus.instr_valid && (state == ST_IDLE);

    assign bus.instr_ready = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_in == OP_SIZE'(OPC_LOAD))
                        next_state = ST_LOAD;
                    else if (op_in == OP_SIZE'(OPC_MOVE))
                        next_state = ST_MOVE;
                    else if (op_in == OP_SIZE'(OPC_ADD) || op_in == OP_SIZE'(OPC_XOR) ||
                             op_in == OP_SIZE'(OPC_SUB) || op_in == OP_SIZE'(OPC_AND))
                        next_state = ST_EX1;
                    else
                        next_state = ST_ERR;
                end
            end
            ST_EX1:  next_state = ST_EX2;
            ST_EX2:  next_state = ST_EX3;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q <= op_in;
                x_q  <= x_in;
                y_q  <= y_in;
            end
        end
    end

    // Strobes decode purely from the registered state, so an asynchronous reset clears them at once.
    always_comb begin
        en_on        = 1'b0;
        tr_on        = 1'b0;
        tr_idx       = x_q;
        bus.data_tri = 1'b0;
        bus.a_en     = 1'b0;
        bus.g_en     = 1'b0;
        bus.g_tri    = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            ST_LOAD: begin
                en_on        = 1'b1;
                bus.data_tri = 1'b1;
                bus.done     = 1'b1;
            end
            ST_MOVE: begin
                en_on    = 1'b1;
                tr_on    = 1'b1;
                tr_idx   = y_q;
                bus.done = 1'b1;
            end
            ST_EX1: begin
                tr_on    = 1'b1;
                bus.a_en = 1'b1;
            end
            ST_EX2: begin
                tr_on      = 1'b1;
                tr_idx     = y_q;
                bus.g_en   = 1'b1;
                bus.alu_op = alu_sel(4'(op_q));
            end
            ST_EX3: begin
                en_on     = 1'b1;
                bus.g_tri = 1'b1;
                bus.done  = 1'b1;
            end
            ST_ERR: begin
                bus.illegal = 1'b1;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    onehot_decoder #(.ARG_SIZE(ARG_SIZE)) u_en_dec (
        .idx    (x_q),
        .en     (en_on),
        .onehot (bus.reg_en)
    );

    onehot_decoder #(.ARG_SIZE(ARG_SIZE)) u_tri_dec (
        .idx    (tr_idx),
        .en     (tr_on),
        .onehot (bus.reg_tri)
    );

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// tb/tb_cpu_ctrl_unit.sv - scoreboard bench for cpu_ctrl_unit at ARG_SIZE 3 and 4
module tb_cpu_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    cpu_ctrl_if bus3 ();
    cpu_ctrl_if #(.OP_SIZE(4), .ARG_SIZE(4)) bus4 ();

    cpu_ctrl_unit u3 (.clk(clk), .rst(rst), .bus(bus3));
    cpu_ctrl_unit #(.OP_SIZE(4), .ARG_SIZE(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));

    // Record: {reg_en[15:0], reg_tri[15:0], data_tri, a_en, g_en, g_tri, alu_op[1:0], done, illegal}
    logic [39:0] q3[$];
    logic [39:0] q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [39:0] mk(input logic [15:0] en, input logic [15:0] tr,
                                       input logic [3:0] dagg, input logic [1:0] alu,
                                       input logic dn, input logic il);
        return {en, tr, dagg, alu, dn, il};
    endfunction

    function automatic logic [39:0] snap3();
        return {8'h00, bus3.reg_en, 8'h00, bus3.reg_tri, bus3.data_tri, bus3.a_en, bus3.g_en,
                bus3.g_tri, bus3.alu_op, bus3.done, bus3.illegal};
    endfunction

    function automatic logic [39:0] snap4();
        return {bus4.reg_en, bus4.reg_tri, bus4.data_tri, bus4.a_en, bus4.g_en,
                bus4.g_tri, bus4.alu_op, bus4.done, bus4.illegal};
    endfunction

    initial begin : mon3
        logic [39:0] act;
        int drv;
        forever begin
            @(negedge clk);
            act = snap3();
            drv = $countones(bus3.reg_tri) + int'(bus3.data_tri) + int'(bus3.g_tri);
            check("dut3_bus_invariant", {62'd0, drv <= 1, $onehot0(bus3.reg_en)}, 64'd3);
            if (bus3.busy) begin
                if (q3.size() == 0) begin
                    checks++;
                    $display("FAIL dut3_unexpected_busy: got %h expected nothing", act);
                end else begin
                    check("dut3_cycle", {24'd0, act}, {24'd0, q3.pop_front()});
                end
            end else begin
                check("dut3_idle", {23'd0, act, bus3.instr_ready}, {23'd0, 40'd0, 1'b1});
            end
        end
    end

    initial begin : mon4
        logic [39:0] act;
        int drv;
        forever begin
            @(negedge clk);
            act = snap4();
            drv = $countones(bus4.reg_tri) + int'(bus4.data_tri) + int'(bus4.g_tri);
            check("dut4_bus_invariant", {62'd0, drv <= 1, $onehot0(bus4.reg_en)}, 64'd3);
            if (bus4.busy) begin
                if (q4.size() == 0) begin
                    checks++;
                    $display("FAIL dut4_unexpected_busy: got %h expected nothing", act);
                end else begin
                    check("dut4_cycle", {24'd0, act}, {24'd0, q4.pop_front()});
                end
            end else begin
                check("dut4_idle", {23'd0, act, bus4.instr_ready}, {23'd0, 40'd0, 1'b1});
            end
        end
    end

    task automatic issue3(input logic [9:0] ins, output int edges);
        logic rdy;
        rdy   = 1'b0;
        edges = 0;
        bus3.instr_valid = 1'b1;
        bus3.instruction = ins;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = bus3.instr_ready;
            @(posedge clk);
            edges++;
            if (rdy) break;
        end
        #1;
        if (!rdy) begin
            checks++;
            $display("FAIL dut3_accept_timeout: got no accept expected accept for %b", ins);
        end
    endtask

    task automatic issue4(input logic [11:0] ins, output int edges);
        logic rdy;
        rdy   = 1'b0;
        edges = 0;
        bus4.instr_valid = 1'b1;
        bus4.instruction = ins;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = bus4.instr_ready;
            @(posedge clk);
            edges++;
            if (rdy) break;
        end
        #1;
        if (!rdy) begin
            checks++;
            $display("FAIL dut4_accept_timeout: got no accept expected accept for %b", ins);
        end
    endtask

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e;
        bus3.instr_valid = 1'b0;
        bus3.instruction = '0;
        bus4.instr_valid = 1'b0;
        bus4.instruction = '0;
        repeat (2) @(negedge clk);
        check("reset_state3", {23'd0, snap3(), bus3.instr_ready}, {23'd0, 40'd0, 1'b1});
        check("reset_busy3", {63'd0, bus3.busy}, 64'd0);
        check("reset_state4", {23'd0, snap4(), bus4.instr_ready}, {23'd0, 40'd0, 1'b1});
        @(posedge clk);
        #1 rst = 1'b1;

        // LOAD R3
        issue3(10'b0000_011_000, e);
        check("load_first_accept_edges", 64'(e), 64'd1);
        q3.push_back(mk(16'h0008, 16'h0000, 4'b1000, 2'b00, 1'b1, 1'b0));
        // ADD R2,R5
        issue3(10'b0010_010_101, e);
        check("load_throughput_edges", 64'(e), 64'd2);
        q3.push_back(mk(16'h0000, 16'h0004, 4'b0100, 2'b00, 1'b0, 1'b0));
        q3.push_back(mk(16'h0000, 16'h0020, 4'b0010, 2'b00, 1'b0, 1'b0));
        q3.push_back(mk(16'h0004, 16'h0000, 4'b0001, 2'b00, 1'b1, 1'b0));
        // SUB R1,R6
        issue3(10'b0100_001_110, e);
        q3.push_back(mk(16'h0000, 16'h0002, 4'b0100, 2'b00, 1'b0, 1'b0));
        q3.push_back(mk(16'h0000, 16'h0040, 4'b0010, 2'b10, 1'b0, 1'b0));
        q3.push_back(mk(16'h0002, 16'h0000, 4'b0001, 2'b00, 1'b1, 1'b0));
        // AND R7,R0
        issue3(10'b0101_111_000, e);
        q3.push_back(mk(16'h0000, 16'h0080, 4'b0100, 2'b00, 1'b0, 1'b0));
        q3.push_back(mk(16'h0000, 16'h0001, 4'b0010, 2'b11, 1'b0, 1'b0));
        q3.push_back(mk(16'h0080, 16'h0000, 4'b0001, 2'b00, 1'b1, 1'b0));
        // Illegal 1111, then the first unused opcode 0110
        issue3(10'b1111_101_010, e);
        q3.push_back(mk(16'h0000, 16'h0000, 4'b0000, 2'b00, 1'b1, 1'b1));
        issue3(10'b0110_000_000, e);
        q3.push_back(mk(16'h0000, 16'h0000, 4'b0000, 2'b00, 1'b1, 1'b1));
        // XOR R4,R3 then MOVE R6,R6 with valid held high
        issue3(10'b0011_100_011, e);
        q3.push_back(mk(16'h0000, 16'h0010, 4'b0100, 2'b00, 1'b0, 1'b0));
        q3.push_back(mk(16'h0000, 16'h0008, 4'b0010, 2'b01, 1'b0, 1'b0));
        q3.push_back(mk(16'h0010, 16'h0000, 4'b0001, 2'b00, 1'b1, 1'b0));
        issue3(10'b0001_110_110, e);
        check("b2b_accept_edges", 64'(e), 64'd4);
        q3.push_back(mk(16'h0040, 16'h0040, 4'b0000, 2'b00, 1'b1, 1'b0));
        bus3.instr_valid = 1'b0;

        // ARG_SIZE = 4: MOVE R15,R9
        issue4(12'b0001_1111_1001, e);
        q4.push_back(mk(16'h8000, 16'h0200, 4'b0000, 2'b00, 1'b1, 1'b0));
        // ADD R3,R10 aborted by reset during EX2
        issue4(12'b0010_0011_1010, e);
        bus4.instr_valid = 1'b0;
        q4.push_back(mk(16'h0000, 16'h0008, 4'b0100, 2'b00, 1'b0, 1'b0));
        q4.push_back(mk(16'h0000, 16'h0400, 4'b0010, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_outputs4", {23'd0, snap4(), bus4.instr_ready}, {23'd0, 40'd0, 1'b1});
        check("abort_busy4", {63'd0, bus4.busy}, 64'd0);
        @(posedge clk);
        #1;
        check("abort_hold4", {24'd0, snap4()}, 64'd0);
        rst = 1'b1;

        repeat (4) @(negedge clk);
        #1;
        check("q3_drained", 64'(q3.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
